// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one digit per slot, guard blanking, frame-boundary commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
module seg_scan_ctrl #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned SLOT_HZ = 1000,
   parameter int unsigned DIGITS  = 8,
   parameter int unsigned GUARD   = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_in,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg,
   output logic                  frame_done,
   output logic                  pending
);

   localparam int unsigned DIV  = CLK_HZ / SLOT_HZ;
   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IdxW = $clog2(DIGITS);

   localparam logic [CntW-1:0] CntLast  = CntW'(DIV - 1);
   localparam logic [CntW-1:0] CntGuard = CntW'(GUARD);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DIGITS - 1);

   typedef enum logic [0:0] {StGuard, StOn} state_e;

   state_e                st_q, st_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
   logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic [DIGITS-1:0]     sh_en_q, sh_en_d, act_en_q, act_en_d;
   logic                  pend_q, pend_d;
   logic                  fd_q, fd_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:0]            seg_q, seg_d;
   logic                  wrap;
   logic [3:0]            nib;
   logic [DIGITS-1:0]     lz_blank;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
      endcase
      return s;
   endfunction

   // Slot timing, FSM phase and double-buffer commit.
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wrap       = 1'b0;
      sh_data_d  = sh_data_q;
      sh_dp_d    = sh_dp_q;
      sh_en_d    = sh_en_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      act_en_d   = act_en_q;
      pend_d     = pend_q;

      if (cnt_q == CntLast) begin
         cnt_d = '0;
         if (idx_q == IdxLast) begin
            idx_d = '0;
            wrap  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      st_d = (cnt_d < CntGuard) ? StGuard : StOn;

      if (upd) begin
         sh_data_d = data_in;
         sh_dp_d   = dp_in;
         sh_en_d   = en_in;
         pend_d    = 1'b1;
      end

      // An upd landing on the wrap edge bypasses the shadow straight into the active set.
      if (wrap) begin
         if (upd) begin
            act_data_d = data_in;
            act_dp_d   = dp_in;
            act_en_d   = en_in;
            pend_d     = 1'b0;
         end else if (pend_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            act_en_d   = sh_en_q;
            pend_d     = 1'b0;
         end
      end

      fd_d = wrap;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic zero_above;

   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above  = zero_above & (act_data_d[4*i +: 4] == 4'h0);
         lz_blank[i] = zero_above & ~act_dp_d[i];
      end
   end
`else
   assign lz_blank = '0;
`endif

   // Outputs are computed from next-state values so the registered an/seg track registered cnt.
   always_comb begin
      an_d  = '0;
      seg_d = '0;
      nib   = act_data_d[{idx_d, 2'b00} +: 4];
      if (st_d == StOn) begin
         if (act_en_d[idx_d] && !lz_blank[idx_d]) begin
            an_d[idx_d] = 1'b1;
         end
         seg_d = {act_dp_d[idx_d], hex7(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= StGuard;
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_data_q  <= '0;
         sh_dp_q    <= '0;
         sh_en_q    <= '0;
         act_data_q <= '0;
         act_dp_q   <= '0;
         act_en_q   <= '0;
         pend_q     <= 1'b0;
         fd_q       <= 1'b0;
         an_q       <= '0;
         seg_q      <= '0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_data_q  <= sh_data_d;
         sh_dp_q    <= sh_dp_d;
         sh_en_q    <= sh_en_d;
         act_data_q <= act_data_d;
         act_dp_q   <= act_dp_d;
         act_en_q   <= act_en_d;
         pend_q     <= pend_d;
         fd_q       <= fd_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = fd_q;
   assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: DIV=10, DIGITS=4, GUARD=2; scoreboard of expected lit cycles.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  en_in = '0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_done;
   logic        pending;

   seg_scan_ctrl #(
      .CLK_HZ (1000),
      .SLOT_HZ(100),
      .DIGITS (4),
      .GUARD  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .upd       (upd),
      .data_in   (data_in),
      .dp_in     (dp_in),
      .en_in     (en_in),
      .an        (an),
      .seg       (seg),
      .frame_done(frame_done),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   t = 0;
   int   cyc = 0;
   logic rst_seen = 1'b1;

   always @(posedge clk) rst_seen <= rst;

   // Monitor: cycle position since reset gives guard/frame timing; lit cycles pop the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      logic fd_exp;
      if (rst_seen) cyc = 0;
      else cyc = cyc + 1;
      fd_exp = !rst_seen && (cyc > 0) && ((cyc % 40) == 0);
      checks++;
      if (frame_done !== fd_exp) begin
         errors++;
         $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done, fd_exp);
      end
      if ((cyc % 10) < 2) begin
         checks++;
         if (an !== 4'h0 || seg !== 8'h00) begin
            errors++;
            $display("FAIL guard_dark cyc=%0d got an=%b seg=%h want an=0000 seg=00", cyc, an, seg);
         end
      end
      if (an !== 4'h0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_lit cyc=%0d got an=%b seg=%h want an=0000", cyc, an, seg);
         end else begin
            e = exp_q.pop_front();
            if ({an, seg} !== e) begin
               errors++;
               $display("FAIL lit_digit cyc=%0d got an=%b seg=%h want an=%b seg=%h",
                        cyc, an, seg, e.an, e.seg);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run_to(input int target);
      while (t < target) tick();
   endtask

   task automatic do_upd(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
      data_in = d;
      dp_in   = dp;
      en_in   = en;
      upd     = 1'b1;
      tick();
      upd     = 1'b0;
   endtask

   task automatic push_slot(input logic [3:0] a, input logic [7:0] s, input int n);
      exp_t e;
      e.an  = a;
      e.seg = s;
      for (int k = 0; k < n; k++) exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [3:0] en, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      if (en[0]) push_slot(4'b0001, s0, 8);
      if (en[1]) push_slot(4'b0010, s1, 8);
      if (en[2]) push_slot(4'b0100, s2, 8);
      if (en[3]) push_slot(4'b1000, s3, 8);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      t   = 0;
      chk("reset_an", an, 4'h0);
      chk("reset_seg", seg, 8'h00);
      chk("reset_pending", pending, 1'b0);
      chk("reset_frame_done", frame_done, 1'b0);

      // Frames 0..4 stay dark; frame 5 still dark while the first update is pending.
      run_to(200);
      do_upd(16'h12AF, 4'b0010, 4'hF);
      chk("pending_after_upd", pending, 1'b1);
      run_to(239);
      chk("pending_before_wrap", pending, 1'b1);
      run_to(240);
      chk("pending_cleared_commit", pending, 1'b0);
      push_frame(4'hF, 8'h71, 8'hF7, 8'h5B, 8'h06);

      // Two mid-frame updates: frame 6 unchanged, frame 7 shows only the last one.
      run_to(245);
      do_upd(16'h8888, 4'h0, 4'hF);
      run_to(270);
      do_upd(16'h0007, 4'h0, 4'hF);
      run_to(279);
      chk("pending_last_wins", pending, 1'b1);
      run_to(280);
      chk("pending_cleared_2", pending, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
      push_frame(4'b0001, 8'h07, 8'h00, 8'h00, 8'h00);
`else
      push_frame(4'hF, 8'h07, 8'h3F, 8'h3F, 8'h3F);
`endif

      // Update on the wrap cycle goes straight to the active set.
      run_to(319);
      chk("pending_idle_at_wrap", pending, 1'b0);
      do_upd(16'h3333, 4'h0, 4'hF);
      chk("pending_bypass", pending, 1'b0);
      push_frame(4'hF, 8'h4F, 8'h4F, 8'h4F, 8'h4F);

      // Enable mask 0101: only slots 0 and 2 light.
      run_to(330);
      do_upd(16'h4321, 4'h0, 4'b0101);
      run_to(360);
      push_frame(4'b0101, 8'h06, 8'h00, 8'h4F, 8'h00);

      // Leading zeros.
      run_to(370);
      do_upd(16'h0050, 4'h0, 4'hF);
      run_to(400);
`ifdef LEADING_ZERO_BLANK_EN
      push_frame(4'b0011, 8'h3F, 8'h6D, 8'h00, 8'h00);
`else
      push_frame(4'hF, 8'h3F, 8'h6D, 8'h3F, 8'h3F);
`endif

      // Reset at cycle 6 of slot 2 with an update pending.
      run_to(440);
      push_frame(4'b0011, 8'h3F, 8'h6D, 8'h00, 8'h00);
`ifndef LEADING_ZERO_BLANK_EN
      push_slot(4'b0100, 8'h3F, 5);
`endif
      run_to(445);
      do_upd(16'hFFFF, 4'hF, 4'hF);
      run_to(466);
      chk("pending_before_rst", pending, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_an", an, 4'h0);
      chk("rst_seg", seg, 8'h00);
      chk("rst_pending", pending, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      t   = 0;

      // Pending update discarded and active cleared: two more dark frames.
      run_to(85);
      chk("pending_after_rst", pending, 1'b0);
      chk("exp_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
